mem_access_stage: RTL and testbench

- Load/store stage directly downstream of the ALU.
- Consumes the ALU's 6-bit instruction code, memory address, write-enable and result, plus the rs2 store data.
- Runs a request/acknowledge transaction on the data-memory port for loads and stores. Produces byte lanes and strobes, and sign/zero-extends load data.
- Presents a registered writeback record. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_stage_pkg.sv | 52 +++++
 rtl/mem_access_stage_load_align_ext.sv | 24 ++
 rtl/mem_access_stage.sv | 214 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the load/store stage: opcode codes common with the ALU,
// the stage FSM states, access sizes and the memory-opcode decoder.
package mem_access_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'b010011;
  localparam logic [5:0] OP_LH  = 6'b010100;
  localparam logic [5:0] OP_LW  = 6'b010101;
  localparam logic [5:0] OP_LBU = 6'b010110;
  localparam logic [5:0] OP_LHU = 6'b010111;
  localparam logic [5:0] OP_SB  = 6'b011000;
  localparam logic [5:0] OP_SH  = 6'b011001;
  localparam logic [5:0] OP_SW  = 6'b011010;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef struct packed {
    logic  is_load;
    logic  is_store;
    size_e size;
    logic  is_unsigned;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t m;
    m.is_load     = 1'b0;
    m.is_store    = 1'b0;
    m.size        = SZ_WORD;
    m.is_unsigned = 1'b0;
    case (op)
      OP_LB:  begin m.is_load = 1'b1; m.size = SZ_BYTE; end
      OP_LH:  begin m.is_load = 1'b1; m.size = SZ_HALF; end
      OP_LW:  begin m.is_load = 1'b1; m.size = SZ_WORD; end
      OP_LBU: begin m.is_load = 1'b1; m.size = SZ_BYTE; m.is_unsigned = 1'b1; end
      OP_LHU: begin m.is_load = 1'b1; m.size = SZ_HALF; m.is_unsigned = 1'b1; end
      OP_SB:  begin m.is_store = 1'b1; m.size = SZ_BYTE; end
      OP_SH:  begin m.is_store = 1'b1; m.size = SZ_HALF; end
      OP_SW:  begin m.is_store = 1'b1; m.size = SZ_WORD; end
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align_ext.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it to 32 bits.
module load_align_ext
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] ext_data
);

  logic [31:0] lane;

  always_comb begin
    lane = rdata >> {byte_off, 3'b000};
    case (size)
      SZ_BYTE: ext_data = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
      SZ_HALF: ext_data = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
      default: ext_data = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Load/store stage: issues req/ack data-memory transactions for loads and stores,
// passes other records through, and emits a registered one-cycle writeback pulse.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        instruction,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0] store_data,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic              alu_wr_en,
  input  logic [4:0]        rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [ADDR_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ack,
  input  logic [ADDR_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [ADDR_W-1:0] wb_data,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [ADDR_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]        dmem_wstrb_q, dmem_wstrb_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [ADDR_W-1:0] wb_data_q, wb_data_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;
  // Context of the outstanding access, needed to shape the load result.
  logic              is_load_q, is_load_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;

  mem_op_t     op;
  logic        misaligned;
  logic [31:0] load_ext;

  load_align_ext u_load_align_ext (
    .rdata       (dmem_rdata[31:0]),
    .byte_off    (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext_data    (load_ext)
  );

  assign op = decode_op(instruction);
  assign misaligned = ((op.size == SZ_HALF) && mem_addr[0]) ||
                      ((op.size == SZ_WORD) && (mem_addr[1:0] != 2'b00));
  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = dmem_wstrb_q;
    wb_valid_d   = 1'b0;
    wb_en_d      = wb_en_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    is_load_d    = is_load_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    rd_d         = rd_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!op.is_load && !op.is_store) begin
            wb_valid_d = 1'b1;
            wb_en_d    = alu_wr_en;
            wb_rd_d    = rd;
            wb_data_d  = alu_result;
          end else if (misaligned) begin
            wb_valid_d = 1'b1;
            misalign_d = 1'b1;
            wb_en_d    = 1'b0;
            wb_rd_d    = rd;
          end else begin
            state_d      = WAIT;
            cnt_d        = '0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = op.is_store;
            dmem_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
            dmem_wdata_d = store_data;
            dmem_wstrb_d = 4'b0000;
            if (op.is_store) begin
              case (op.size)
                SZ_BYTE: begin
                  dmem_wdata_d = ADDR_W'({4{store_data[7:0]}});
                  dmem_wstrb_d = 4'(4'b0001 << mem_addr[1:0]);
                end
                SZ_HALF: begin
                  dmem_wdata_d = ADDR_W'({2{store_data[15:0]}});
                  dmem_wstrb_d = 4'(4'b0011 << mem_addr[1:0]);
                end
                default: dmem_wstrb_d = 4'b1111;
              endcase
            end
            is_load_d = op.is_load;
            size_d    = op.size;
            uns_d     = op.is_unsigned;
            off_d     = mem_addr[1:0];
            rd_d      = rd;
          end
        end
      end
      WAIT: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (dmem_ack) begin
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_en_d    = is_load_q;
          wb_rd_d    = rd_q;
          if (is_load_q) wb_data_d = ADDR_W'(load_ext);
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          wb_valid_d = 1'b1;
          bus_err_d  = 1'b1;
          wb_en_d    = 1'b0;
          wb_rd_d    = rd_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= 4'b0000;
      wb_valid_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      is_load_q    <= 1'b0;
      size_q       <= SZ_WORD;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      wb_valid_q   <= wb_valid_d;
      wb_en_q      <= wb_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
      is_load_q    <= is_load_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
    end
  end

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_wstrb   = dmem_wstrb_q;
  assign wb_valid     = wb_valid_q;
  assign wb_en        = wb_en_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage with a short ack timeout,
// plus hand-written sequences for timeout, reset mid-access and back-to-back flow.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  instruction;
  logic [31:0] mem_addr, store_data, alu_result;
  logic        alu_wr_en;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .mem_addr(mem_addr), .store_data(store_data),
    .alu_result(alu_result), .alu_wr_en(alu_wr_en), .rd(rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  typedef struct {
    logic [5:0]  instr;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] alu;
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          ack_dly;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        exp_wb_en;
    logic [31:0] exp_wb_data;
    logic        exp_mis;
    logic        chk_data;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] ins, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] alu, input logic we, input logic [4:0] r);
    in_valid    = 1'b1;
    instruction = ins;
    mem_addr    = a;
    store_data  = sd;
    alu_result  = alu;
    alu_wr_en   = we;
    rd          = r;
  endtask

  initial begin
    // instr, addr, sdata, alu, wr_en, rd, rdata, ack_dly,
    // exp_req, exp_we, exp_wstrb, exp_wdata, exp_wb_en, exp_wb_data, exp_mis, chk_data
    vecs[0]  = '{6'b000000, 32'h0, 32'h0, 32'h0000_0005, 1'b1, 5'd3, 32'h0, 0,
                 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0000_0005, 1'b0, 1'b1};
    vecs[1]  = '{6'b000001, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 0,
                 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[2]  = '{6'b010011, 32'h0000_0103, 32'h0, 32'h0, 1'b1, 5'd4, 32'h80FF_1234, 3,
                 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1};
    vecs[3]  = '{6'b010110, 32'h0000_0103, 32'h0, 32'h0, 1'b1, 5'd5, 32'h80FF_1234, 3,
                 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0000_0080, 1'b0, 1'b1};
    vecs[4]  = '{6'b010100, 32'h0000_0102, 32'h0, 32'h0, 1'b1, 5'd6, 32'h80FF_1234, 1,
                 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFF_80FF, 1'b0, 1'b1};
    vecs[5]  = '{6'b010111, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 5'd7, 32'h80FF_9234, 0,
                 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0000_9234, 1'b0, 1'b1};
    vecs[6]  = '{6'b010101, 32'h0000_0204, 32'h0, 32'h0, 1'b1, 5'd8, 32'hCAFE_F00D, 2,
                 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1};
    vecs[7]  = '{6'b010011, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 5'd9, 32'h80FF_1234, 0,
                 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0000_0012, 1'b0, 1'b1};
    vecs[8]  = '{6'b011001, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 1'b1, 5'd10, 32'h0, 1,
                 1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[9]  = '{6'b011000, 32'h0000_0301, 32'h1234_56A5, 32'h0, 1'b1, 5'd11, 32'h0, 0,
                 1'b1, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[10] = '{6'b011010, 32'h0000_040C, 32'h1122_3344, 32'h0, 1'b1, 5'd12, 32'h0, 2,
                 1'b1, 1'b1, 4'b1111, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[11] = '{6'b010101, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 5'd13, 32'h0, 0,
                 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[12] = '{6'b011001, 32'h0000_0203, 32'h0, 32'h0, 1'b1, 5'd14, 32'h0, 0,
                 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[13] = '{6'b010100, 32'h0000_0105, 32'h0, 32'h0, 1'b1, 5'd15, 32'h0, 0,
                 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; instruction = '0; mem_addr = '0; store_data = '0;
    alu_result = '0; alu_wr_en = 1'b0; rd = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) step();

    check("rst dmem_req", 32'(dmem_req), 32'h0);
    check("rst dmem_we", 32'(dmem_we), 32'h0);
    check("rst dmem_wstrb", 32'(dmem_wstrb), 32'h0);
    check("rst dmem_addr", dmem_addr, 32'h0);
    check("rst dmem_wdata", dmem_wdata, 32'h0);
    check("rst wb_valid", 32'(wb_valid), 32'h0);
    check("rst wb_en", 32'(wb_en), 32'h0);
    check("rst wb_rd", 32'(wb_rd), 32'h0);
    check("rst wb_data", wb_data, 32'h0);
    check("rst misalign_err", 32'(misalign_err), 32'h0);
    check("rst bus_err", 32'(bus_err), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    step();

    // Ack while idle must not produce anything.
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    step();
    dmem_ack = 1'b0;
    step();
    check("idle ack wb_valid", 32'(wb_valid), 32'h0);
    check("idle ack dmem_req", 32'(dmem_req), 32'h0);

    for (int i = 0; i < 14; i++) begin
      present(vecs[i].instr, vecs[i].addr, vecs[i].sdata, vecs[i].alu, vecs[i].wr_en, vecs[i].rd);
      step();
      in_valid = 1'b0;
      if (vecs[i].exp_req) begin
        check($sformatf("v%0d dmem_req", i), 32'(dmem_req), 32'h1);
        check($sformatf("v%0d dmem_we", i), 32'(dmem_we), 32'(vecs[i].exp_we));
        check($sformatf("v%0d dmem_addr", i), dmem_addr, vecs[i].addr & 32'hFFFF_FFFC);
        check($sformatf("v%0d dmem_wstrb", i), 32'(dmem_wstrb), 32'(vecs[i].exp_wstrb));
        if (vecs[i].exp_we)
          check($sformatf("v%0d dmem_wdata", i), dmem_wdata, vecs[i].exp_wdata);
        check($sformatf("v%0d in_ready wait", i), 32'(in_ready), 32'h0);
        for (int k = 0; k < vecs[i].ack_dly; k++) begin
          step();
          check($sformatf("v%0d req held", i), 32'(dmem_req), 32'h1);
          check($sformatf("v%0d no early wb", i), 32'(wb_valid), 32'h0);
        end
        dmem_ack = 1'b1; dmem_rdata = vecs[i].rdata;
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        check($sformatf("v%0d req dropped", i), 32'(dmem_req), 32'h0);
      end else begin
        check($sformatf("v%0d no dmem_req", i), 32'(dmem_req), 32'h0);
      end
      check($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'h1);
      check($sformatf("v%0d wb_en", i), 32'(wb_en), 32'(vecs[i].exp_wb_en));
      check($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
      check($sformatf("v%0d misalign_err", i), 32'(misalign_err), 32'(vecs[i].exp_mis));
      check($sformatf("v%0d bus_err", i), 32'(bus_err), 32'h0);
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'h1);
      if (vecs[i].chk_data)
        check($sformatf("v%0d wb_data", i), wb_data, vecs[i].exp_wb_data);
      $display("vec %0d instr %b addr %h wb_en %0d wb_rd %0d wb_data %h misalign %0d",
               i, vecs[i].instr, vecs[i].addr, wb_en, wb_rd, wb_data, misalign_err);
      step();
      check($sformatf("v%0d wb_valid pulse", i), 32'(wb_valid), 32'h0);
      check($sformatf("v%0d misalign pulse", i), 32'(misalign_err), 32'h0);
    end

    // Timeout: SW never acked, request must stay up exactly TIMEOUT_CYCLES cycles.
    begin
      int req_cycles;
      present(6'b011010, 32'h0000_0500, 32'h5555_AAAA, 32'h0, 1'b1, 5'd16);
      step();
      in_valid = 1'b0;
      req_cycles = 0;
      while (dmem_req && req_cycles < 20) begin
        check("timeout in_ready low", 32'(in_ready), 32'h0);
        req_cycles++;
        step();
      end
      check("timeout req cycles", 32'(req_cycles), 32'd4);
      check("timeout wb_valid", 32'(wb_valid), 32'h1);
      check("timeout bus_err", 32'(bus_err), 32'h1);
      check("timeout wb_en", 32'(wb_en), 32'h0);
      check("timeout in_ready", 32'(in_ready), 32'h1);
      $display("timeout req_cycles %0d bus_err %0d", req_cycles, bus_err);
      step();
      check("timeout bus_err pulse", 32'(bus_err), 32'h0);
    end

    // Reset in the middle of a wait.
    present(6'b010101, 32'h0000_0600, 32'h0, 32'h0, 1'b1, 5'd17);
    step();
    in_valid = 1'b0;
    step();
    check("midrst req before", 32'(dmem_req), 32'h1);
    rst = 1'b1;
    step();
    check("midrst dmem_req", 32'(dmem_req), 32'h0);
    check("midrst wb_valid", 32'(wb_valid), 32'h0);
    rst = 1'b0;
    step();
    check("midrst wb_valid after", 32'(wb_valid), 32'h0);
    check("midrst in_ready", 32'(in_ready), 32'h1);
    $display("midrst dmem_req %0d wb_valid %0d", dmem_req, wb_valid);

    // Back-to-back: LW acked, ADD presented in the writeback cycle.
    present(6'b010101, 32'h0000_0700, 32'h0, 32'h0, 1'b1, 5'd18);
    step();
    in_valid = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h0102_0304;
    step();
    dmem_ack = 1'b0;
    check("b2b lw wb_valid", 32'(wb_valid), 32'h1);
    check("b2b lw wb_data", wb_data, 32'h0102_0304);
    check("b2b lw wb_rd", 32'(wb_rd), 32'd18);
    check("b2b in_ready", 32'(in_ready), 32'h1);
    present(6'b000000, 32'h0, 32'h0, 32'h0000_0007, 1'b1, 5'd9);
    step();
    in_valid = 1'b0;
    check("b2b add wb_valid", 32'(wb_valid), 32'h1);
    check("b2b add wb_data", wb_data, 32'h0000_0007);
    check("b2b add wb_rd", 32'(wb_rd), 32'd9);
    check("b2b add no req", 32'(dmem_req), 32'h0);
    $display("b2b add wb_rd %0d wb_data %h", wb_rd, wb_data);
    step();
    check("b2b end wb_valid", 32'(wb_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
